// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared state encodings and defaults for the frequency channel scheduler
package freq_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_SETTLE  = 3'd2;
   localparam logic [2:0] ST_MEASURE = 3'd3;
   localparam logic [2:0] ST_NEXT    = 3'd4;

   localparam int          SETTLE_DEFAULT  = 4;
   localparam logic [15:0] TIMEOUT_DEFAULT = 16'd8191;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - round-robin search for the first set mask bit strictly after last
module rr_select #(
   parameter int N = 4,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] last,
   output logic [W-1:0] next,
   output logic         any
);

   logic [W-1:0] idx;

   // Scanning from the farthest offset down leaves the nearest hit; offset N wraps to last itself.
   always_comb begin
      next = last;
      idx  = last;
      for (int i = N; i >= 1; i--) begin
         idx = last + W'(i);
         if (mask[idx]) next = idx;
      end
   end

   assign any = |mask;

endmodule

// File: rtl/freq_channel_scheduler.sv
// rtl/freq_channel_scheduler.sv - time-shares one frequency counter across CHANNELS input signals
module freq_channel_scheduler
   import freq_pkg::*;
#(
   parameter int          CHANNELS     = 4,
   parameter int          BITS         = 12,
   parameter int          SETTLE       = SETTLE_DEFAULT,
   parameter logic [15:0] TIMEOUT      = TIMEOUT_DEFAULT,
   parameter int          RESET_PERIOD = 1199,
   localparam int         CW           = $clog2(CHANNELS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] signals,
   input  logic [CHANNELS-1:0] chan_enable,
   input  logic                cfg_we,
   input  logic [CW-1:0]       cfg_chan,
   input  logic [BITS-1:0]     cfg_period,
   input  logic                meas_done,
   output logic                signal_out,
   output logic [BITS-1:0]     period,
   output logic                period_load,
   output logic                counter_clr,
   output logic [CW-1:0]       active_chan,
   output logic                busy,
   output logic                done_pulse,
   output logic [CW-1:0]       done_chan,
   output logic [CHANNELS-1:0] timeout_err
);

   logic [2:0]      state;
   logic [3:0]      settle_cnt;
   logic [15:0]     tmo_cnt;
   logic [BITS-1:0] period_reg [CHANNELS];
   logic [CW-1:0]   rr_next;
   logic            rr_any;
   logic            chan_live;

   // active_chan doubles as the last-served pointer for the round-robin search.
   rr_select #(.N(CHANNELS)) u_rr (
      .mask (chan_enable),
      .last (active_chan),
      .next (rr_next),
      .any  (rr_any)
   );

   assign chan_live   = chan_enable[active_chan];
   assign busy        = (state != ST_IDLE);
   assign period_load = (state == ST_LOAD);
   assign counter_clr = (state != ST_MEASURE);
   assign period      = period_load ? period_reg[active_chan] : '0;
   assign signal_out  = busy & signals[active_chan];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         active_chan <= CW'(CHANNELS - 1);
         settle_cnt  <= '0;
         tmo_cnt     <= '0;
         done_pulse  <= 1'b0;
         done_chan   <= '0;
         timeout_err <= '0;
         for (int i = 0; i < CHANNELS; i++) period_reg[i] <= BITS'(RESET_PERIOD);
      end else begin
         done_pulse <= 1'b0;
         case (state)
            ST_IDLE, ST_NEXT: begin
               if (rr_any) begin
                  active_chan <= rr_next;
                  state       <= ST_LOAD;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               settle_cnt <= '0;
               tmo_cnt    <= '0;
               state      <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (!chan_live) state <= ST_NEXT;
               else if (settle_cnt == 4'(SETTLE - 1)) state <= ST_MEASURE;
               else settle_cnt <= settle_cnt + 4'd1;
            end
            ST_MEASURE: begin
               tmo_cnt <= tmo_cnt + 16'd1;
               // A completed measurement beats a timeout landing on the same cycle.
               if (!chan_live) begin
                  state <= ST_NEXT;
               end else if (meas_done) begin
                  done_pulse <= 1'b1;
                  done_chan  <= active_chan;
                  state      <= ST_NEXT;
               end else if (tmo_cnt + 16'd1 == TIMEOUT) begin
                  timeout_err[active_chan] <= 1'b1;
                  state                    <= ST_NEXT;
               end
            end
            default: state <= ST_IDLE;
         endcase
         if (cfg_we) begin
            period_reg[cfg_chan]  <= cfg_period;
            timeout_err[cfg_chan] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_freq_channel_scheduler.sv
// tb/tb_freq_channel_scheduler.sv - directed self-checking bench for freq_channel_scheduler
module tb_freq_channel_scheduler;

   localparam int SETTLE_CYC = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  signals = '0;
   logic [3:0]  chan_enable = 4'b1111;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_chan = '0;
   logic [11:0] cfg_period = '0;
   logic        meas_done = 1'b0;
   logic        signal_out;
   logic [11:0] period;
   logic        period_load;
   logic        counter_clr;
   logic [1:0]  active_chan;
   logic        busy;
   logic        done_pulse;
   logic [1:0]  done_chan;
   logic [3:0]  timeout_err;

   int n_chk = 0;
   int n_err = 0;

   freq_channel_scheduler #(
      .CHANNELS(4), .BITS(12), .SETTLE(SETTLE_CYC), .TIMEOUT(16'd100), .RESET_PERIOD(1199)
   ) dut (
      .clk(clk), .reset(reset), .signals(signals), .chan_enable(chan_enable),
      .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_period(cfg_period), .meas_done(meas_done),
      .signal_out(signal_out), .period(period), .period_load(period_load),
      .counter_clr(counter_clr), .active_chan(active_chan), .busy(busy),
      .done_pulse(done_pulse), .done_chan(done_chan), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_load(input string tag, input int exp_ch, input int exp_per);
      bit seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         tick();
         if (period_load) seen = 1'b1;
      end
      check({tag, "_load_seen"}, 32'(seen), 1);
      check({tag, "_load_chan"}, 32'(active_chan), exp_ch);
      check({tag, "_period"}, 32'(period), exp_per);
   endtask

   // Called in the LOAD cycle; pulses meas_done in MEASURE cycle done_at.
   task automatic finish_round(input string tag, input int exp_ch, input int done_at);
      repeat (SETTLE_CYC) tick();
      check({tag, "_settle_clr"}, 32'(counter_clr), 1);
      tick();
      check({tag, "_measure_clr"}, 32'(counter_clr), 0);
      repeat (done_at - 1) tick();
      meas_done = 1'b1;
      tick();
      meas_done = 1'b0;
      check({tag, "_done_pulse"}, 32'(done_pulse), 1);
      check({tag, "_done_chan"}, 32'(done_chan), exp_ch);
   endtask

   initial begin
      #2 reset = 1'b1;
      repeat (2) tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_clr", 32'(counter_clr), 1);
      check("rst_period", 32'(period), 0);
      check("rst_load", 32'(period_load), 0);
      check("rst_done", 32'(done_pulse), 0);
      check("rst_err", 32'(timeout_err), 0);
      check("rst_active", 32'(active_chan), 3);
      reset = 1'b0;

      // Full round-robin over all four channels.
      for (int r = 0; r < 5; r++) begin
         wait_load("rr", r % 4, 1199);
         finish_round("rr", r % 4, 50);
      end
      tick();
      check("done_one_cycle", 32'(done_pulse), 0);

      // Single enabled channel is reselected every round.
      chan_enable = 4'b0100;
      for (int r = 0; r < 2; r++) begin
         wait_load("single", 2, 1199);
         finish_round("single", 2, 20);
      end
      wait_load("single3", 2, 1199);
      repeat (SETTLE_CYC + 1) tick();
      signals = 4'b0100;
      #1 check("sig_hi", 32'(signal_out), 1);
      signals = 4'b1011;
      #1 check("sig_lo", 32'(signal_out), 0);
      chan_enable = 4'b0000;
      tick();
      check("abort_no_done", 32'(done_pulse), 0);
      tick();
      check("idle_busy", 32'(busy), 0);
      check("idle_sig", 32'(signal_out), 0);
      check("abort_no_err", 32'(timeout_err), 0);
      tick();
      check("idle_stays", 32'(busy), 0);

      // Timeout on channel 0, then channel 1 served; cfg write clears the error.
      chan_enable = 4'b0011;
      wait_load("tmo", 0, 1199);
      repeat (SETTLE_CYC + 1 + 99) tick();
      check("tmo_not_yet", 32'(timeout_err), 0);
      tick();
      check("tmo_set", 32'(timeout_err), 4'b0001);
      check("tmo_no_done", 32'(done_pulse), 0);
      wait_load("after_tmo", 1, 1199);
      finish_round("after_tmo", 1, 20);
      cfg_we = 1'b1; cfg_chan = 2'd0; cfg_period = 12'd777;
      tick();
      cfg_we = 1'b0;
      check("cfg_clr_err", 32'(timeout_err), 0);
      check("cfg_load", 32'(period_load), 1);
      check("cfg_new_period", 32'(period), 777);

      // meas_done lands on the timeout cycle: done wins.
      finish_round("race", 0, 100);
      check("race_no_err", 32'(timeout_err), 0);

      // Mid-MEASURE write to the active channel defers to its next LOAD.
      wait_load("midw", 1, 1199);
      repeat (SETTLE_CYC + 1 + 9) tick();
      cfg_we = 1'b1; cfg_chan = 2'd1; cfg_period = 12'd500;
      tick();
      cfg_we = 1'b0;
      check("midw_no_reload", 32'(period_load), 0);
      check("midw_still_meas", 32'(counter_clr), 0);
      repeat (39) tick();
      meas_done = 1'b1;
      tick();
      meas_done = 1'b0;
      check("midw_done", 32'(done_pulse), 1);
      wait_load("midw_ch0", 0, 777);
      finish_round("midw_ch0", 0, 30);
      wait_load("midw_next", 1, 500);

      // Reset in the middle of MEASURE.
      repeat (SETTLE_CYC + 1 + 10) tick();
      #2 reset = 1'b1;
      #1;
      check("mrst_busy", 32'(busy), 0);
      check("mrst_clr", 32'(counter_clr), 1);
      check("mrst_active", 32'(active_chan), 3);
      meas_done = 1'b1;
      tick();
      meas_done = 1'b0;
      check("mrst_no_done", 32'(done_pulse), 0);
      reset = 1'b0;
      check("mrst_err", 32'(timeout_err), 0);
      wait_load("mrst_first", 0, 1199);

      // meas_done during SETTLE is ignored.
      meas_done = 1'b1;
      repeat (SETTLE_CYC) tick();
      meas_done = 1'b0;
      check("settle_done_ignored", 32'(done_pulse), 0);
      tick();
      check("settle_then_meas", 32'(counter_clr), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
